led_nios2_qsys_dct_unpacker: RTL
================================

Name: led_nios2_qsys_dct_unpacker

Overview:
Consumer-side counterpart to the OCI data-compression-trace (DCT) packer. It accepts a packed 30-bit DCT buffer word, which holds up to 15 two-bit trace atoms, together with its 4-bit valid-atom count. It then replays the atoms one per handshake, LSB-first, onto a streaming atom port that feeds the trace-export serializer. The block also supports flush and keeps running statistics for debug readback.

Parameters:
ATOM_W, 2, bits per trace atom.
NUM_ATOMS, 15, atom slots per buffer word; buffer width = ATOM_W*NUM_ATOMS = 30.
CNT_W, 4, width of dct_count; must satisfy 2**CNT_W > NUM_ATOMS.
TOT_W, 16, width of the atom_total statistics counter.

Ports:
clk  in  1  single system clock; all logic is rising-edge.
reset  in  1  synchronous, active-high reset.
dct_buffer  in  30  packed atoms; atom k occupies bits [2k+1:2k].
dct_count  in  4  number of valid atoms in dct_buffer (0..15).
dct_valid  in  1  buffer word offered.
dct_ready  out  1  unpacker can accept a buffer word.
flush  in  1  abandon the remaining atoms of the current buffer.
atom_data  out  2  current atom.
atom_valid  out  1  atom_data is valid.
atom_ready  in  1  downstream accepts the atom.
atom_last  out  1  current atom is the final valid atom of its buffer.
zero_drop  out  1  one-cycle pulse: a buffer with count 0 was accepted and discarded.
flushed  out  1  one-cycle pulse: a flush discarded at least one atom.
atom_total  out  16  count of atoms transferred (valid&&ready), wraps modulo 2**16.

Behaviour:
- Reset: state=IDLE, shift register=0, remaining=0. Outputs after reset: dct_ready=1, atom_valid=0, atom_data=0, atom_last=0, zero_drop=0, flushed=0, atom_total=0. Reset asserted mid-buffer discards the buffer immediately, with no flushed pulse.
- FSM has two states, IDLE and SHIFT.
- IDLE:
  - dct_ready=1 and atom_valid=0.
  - If dct_valid and dct_count!=0: latch dct_buffer into sreg, set remaining=dct_count, go to SHIFT. atom_valid goes high the next cycle (load-to-first-atom latency = 1 cycle).
  - If dct_valid and dct_count==0: stay in IDLE and pulse zero_drop for one cycle, registered so it appears the next cycle.
  - Flush in IDLE has no effect.
- SHIFT:
  - dct_ready=0, atom_valid=1.
  - atom_data=sreg[1:0], atom_last=(remaining==1).
  - On atom_valid&&atom_ready: sreg is shifted right by ATOM_W with zero fill, remaining decrements, and atom_total increments. If remaining was 1, go to IDLE.
  - atom_data and atom_last hold stable while atom_ready=0 (AXI-stream-style: once valid, the atom stays valid until accepted).
- Flush in SHIFT takes priority over normal progression:
  - The atom presented that cycle still transfers if atom_ready=1, and atom_total counts it.
  - All other remaining atoms are discarded and the next state is IDLE.
  - flushed pulses the next cycle only if at least one atom was discarded. flush+ready on the last atom therefore gives no pulse.
- Throughput: a buffer of N atoms occupies N+1 cycles minimum (1 load cycle + N transfer cycles). dct_ready reasserts the cycle after the last atom handshake. There is no overlap of load and drain.
- Upper slot bits beyond count are ignored; the unpacker never emits more than dct_count atoms.
- dct_count values up to 15 are all legal. No overflow case exists for the default parameters.
- atom_total wraps from 0xFFFF to 0x0000 silently.
- atom_data reads 0 in IDLE.

Test Plan:
1. Reset, then load buffer 0x3FFF_FFE4 (atoms 0,1,2,3,3,...) with count=4 and atom_ready held high -> atom_data sequence 0,1,2,3 on 4 consecutive cycles starting 1 cycle after the load; atom_last high only on the 4th; dct_ready returns the following cycle; atom_total=4.
2. Count=15, buffer 0x2AAA_AAAA, with atom_ready toggled 1,0,1,0 -> 15 atoms all equal to 2; data and last stable during stalls; exactly 15 transfers; atom_last only on the 15th.
3. Count=0 with dct_valid -> zero_drop pulses for exactly one cycle, atom_valid never rises, atom_total unchanged.
4. Count=6, assert flush together with atom_ready on the 3rd atom -> atoms 1-3 transferred, 3 discarded, flushed pulses once, atom_total+=3, dct_ready high the next cycle. Repeat with flush on the 6th (last) atom -> no flushed pulse.
5. Assert reset mid-buffer (count=10 after 4 transfers) -> the next cycle shows IDLE outputs, atom_total=0, and no flushed pulse.
6. Preload atom_total to 0xFFFE via 65534 transfers (or force), then transfer 3 atoms -> final value 0x0001.

Source files
------------

// File: rtl/led_nios2_qsys_dct_unpacker.sv
// DCT unpacker: accepts a packed buffer of trace atoms plus a valid-atom count
// and replays the atoms LSB-first, one per valid/ready handshake.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. dct_ready is high only in IDLE. atom_valid is high only in SHIFT, and
// once raised atom_data/atom_last hold until atom_ready accepts the atom.
module led_nios2_qsys_dct_unpacker #(
    parameter int ATOM_W    = 2,
    parameter int NUM_ATOMS = 15,
    parameter int CNT_W     = 4,
    parameter int TOT_W     = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [ATOM_W*NUM_ATOMS-1:0] dct_buffer,
    input  logic [CNT_W-1:0]            dct_count,
    input  logic                        dct_valid,
    output logic                        dct_ready,
    input  logic                        flush,
    output logic [ATOM_W-1:0]           atom_data,
    output logic                        atom_valid,
    input  logic                        atom_ready,
    output logic                        atom_last,
    output logic                        zero_drop,
    output logic                        flushed,
    output logic [TOT_W-1:0]            atom_total
);

    localparam int BUF_W = ATOM_W * NUM_ATOMS;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [BUF_W-1:0]   sreg;
    logic [CNT_W-1:0]   remaining;
    logic               zero_drop_q;
    logic               flushed_q;
    logic [TOT_W-1:0]   total_q;

    logic               load;
    logic               xfer;
    logic               on_last;

    assign load    = (state == IDLE) && dct_valid && (dct_count != '0);
    assign xfer    = (state == SHIFT) && atom_ready;
    assign on_last = (remaining == CNT_W'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and handshake/atom outputs; flush overrides normal draining.
    always_comb begin
        state_next = state;
        dct_ready  = 1'b0;
        atom_valid = 1'b0;
        atom_data  = '0;
        atom_last  = 1'b0;
        case (state)
            IDLE: begin
                dct_ready = 1'b1;
                if (load) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                atom_valid = 1'b1;
                atom_data  = sreg[ATOM_W-1:0];
                atom_last  = on_last;
                if (flush || (atom_ready && on_last)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Shift register, remaining count, event pulses and transfer statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg        <= '0;
            remaining   <= '0;
            zero_drop_q <= 1'b0;
            flushed_q   <= 1'b0;
            total_q     <= '0;
        end else begin
            zero_drop_q <= (state == IDLE) && dct_valid && (dct_count == '0);
            flushed_q   <= 1'b0;
            if (xfer) begin
                total_q <= total_q + TOT_W'(1);
            end
            if (load) begin
                sreg      <= dct_buffer;
                remaining <= dct_count;
            end else if (state == SHIFT) begin
                if (flush) begin
                    // Something is discarded unless the flushed atom was the last one and it transferred.
                    flushed_q <= xfer ? !on_last : 1'b1;
                    sreg      <= '0;
                    remaining <= '0;
                end else if (xfer) begin
                    sreg      <= sreg >> ATOM_W;
                    remaining <= remaining - CNT_W'(1);
                end
            end
        end
    end

    assign zero_drop  = zero_drop_q;
    assign flushed    = flushed_q;
    assign atom_total = total_q;

endmodule
